// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, shift out
// data/parity/stop on device clock falling edges, then check the device ACK.
`timescale 1ns/1ps
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 3000,
    parameter int TIMEOUT_CYCLES = 500000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data_in,
    output logic       busy,
    output logic       done,
    output logic       error,
    input  logic       ps_clock,
    input  logic       ps_data,
    output logic       ps_clock_oe,
    output logic       ps_data_oe
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_RELEASE, S_SEND, S_ACK, S_FINISH
    } state_t;

    state_t           state_q;
    logic [9:0]       shift_q;
    logic [INH_W-1:0] inh_cnt_q;
    logic [3:0]       bit_cnt_q;
    logic [WD_W-1:0]  wd_q;
    logic             nack_q;
    logic             busy_q, done_q, error_q, clk_oe_q, data_oe_q;
    logic [1:0]       clk_sync_q, data_sync_q;
    logic             clk_prev_q;

    logic fall_edge;
    logic wd_active;
    logic timeout;

    // Synchronizers idle high so reset never fakes a falling edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_prev_q  <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps_clock};
            data_sync_q <= {data_sync_q[0], ps_data};
            clk_prev_q  <= clk_sync_q[1];
        end
    end

    assign fall_edge = clk_prev_q & ~clk_sync_q[1];
    assign wd_active = (state_q == S_SEND) || (state_q == S_ACK) || (state_q == S_FINISH);
    assign timeout   = wd_active && !fall_edge && (wd_q == WD_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            inh_cnt_q <= '0;
            bit_cnt_q <= '0;
            wd_q      <= '0;
            nack_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            if (wd_active) begin
                if (fall_edge)
                    wd_q <= '0;
                else
                    wd_q <= wd_q + 1'b1;
            end
            if (timeout) begin
                clk_oe_q  <= 1'b0;
                data_oe_q <= 1'b0;
                error_q   <= 1'b1;
                busy_q    <= 1'b0;
                state_q   <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            shift_q   <= {1'b1, ~^data_in, data_in};
                            inh_cnt_q <= '0;
                            clk_oe_q  <= 1'b1;
                            busy_q    <= 1'b1;
                            state_q   <= S_INHIBIT;
                        end
                    end
                    S_INHIBIT: begin
                        inh_cnt_q <= inh_cnt_q + 1'b1;
                        if (inh_cnt_q == INH_LAST) begin
                            data_oe_q <= 1'b1;
                            state_q   <= S_RELEASE;
                        end
                    end
                    S_RELEASE: begin
                        clk_oe_q  <= 1'b0;
                        bit_cnt_q <= '0;
                        wd_q      <= '0;
                        state_q   <= S_SEND;
                    end
                    S_SEND: begin
                        // Pin is open-drain: a 1 bit means release, a 0 bit means pull low.
                        if (fall_edge) begin
                            data_oe_q <= ~shift_q[0];
                            shift_q   <= {1'b0, shift_q[9:1]};
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                            if (bit_cnt_q == 4'd9)
                                state_q <= S_ACK;
                        end
                    end
                    S_ACK: begin
                        if (fall_edge) begin
                            nack_q  <= data_sync_q[1];
                            state_q <= S_FINISH;
                        end
                    end
                    S_FINISH: begin
                        if (clk_sync_q[1]) begin
                            done_q  <= ~nack_q;
                            error_q <= nack_q;
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;
    assign ps_clock_oe = clk_oe_q;
    assign ps_data_oe  = data_oe_q;

endmodule
